wm_panel_ctrl: RTL and testbench

- Input-side counterpart of the washing-machine LED display block.
- Takes four raw front-panel push-buttons, then synchronises, debounces and edge-detects them.
- Holds the user's course, water-level and temperature selections.
- Sequences the selected wash/rinse/dry phases on start; its outputs are the selection/status signals the LED display renders.

---
 rtl/wm_panel_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wm_panel_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_panel_ctrl.sv
// Washing-machine front-panel controller: button conditioning, user settings
// and the wash/rinse/dry sequencer whose outputs feed the LED display block.
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int PHASE_CYC    = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_course,
  input  logic       btn_water,
  input  logic       btn_temp,
  input  logic       btn_start,
  output logic [2:0] course_sel,
  output logic [1:0] water_lvl,
  output logic [1:0] temp_sel,
  output logic       running,
  output logic [2:0] phase,
  output logic       done
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam int PH_W = $clog2(PHASE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_DRY, S_DONE} state_t;

  function automatic logic [2:0] next_course(input logic [2:0] cur);
    case (cur)
      3'b111:  next_course = 3'b100;
      3'b100:  next_course = 3'b010;
      3'b010:  next_course = 3'b001;
      3'b001:  next_course = 3'b110;
      3'b110:  next_course = 3'b011;
      default: next_course = 3'b111;
    endcase
  endfunction

  // Shared by water level and temperature: 01 -> 10 -> 11 -> 01.
  function automatic logic [1:0] next_level(input logic [1:0] cur);
    case (cur)
      2'b01:   next_level = 2'b10;
      2'b10:   next_level = 2'b11;
      default: next_level = 2'b01;
    endcase
  endfunction

  function automatic state_t phase_after(input state_t cur, input logic [2:0] sel);
    phase_after = S_DONE;
    case (cur)
      S_IDLE: begin
        if (sel[2])      phase_after = S_WASH;
        else if (sel[1]) phase_after = S_RINSE;
        else if (sel[0]) phase_after = S_DRY;
      end
      S_WASH: begin
        if (sel[1])      phase_after = S_RINSE;
        else if (sel[0]) phase_after = S_DRY;
      end
      S_RINSE: begin
        if (sel[0])      phase_after = S_DRY;
      end
      default: phase_after = S_DONE;
    endcase
  endfunction

  logic [3:0]      raw;
  logic [3:0]      sync_p0, sync_p1, stable_p2, stable_p3, press_p3;
  logic [DB_W-1:0] db_cnt [4];

  assign raw = {btn_start, btn_temp, btn_water, btn_course};

  // p0/p1: synchroniser, p2: debounced level, p3: rising-edge press pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      stable_p3 <= '0;
      press_p3  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0   <= raw;
      sync_p1   <= sync_p0;
      stable_p3 <= stable_p2;
      press_p3  <= stable_p2 & ~stable_p3;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable_p2[i] <= ~stable_p2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic press_course, press_water, press_temp, press_start;
  assign press_course = press_p3[0];
  assign press_water  = press_p3[1];
  assign press_temp   = press_p3[2];
  assign press_start  = press_p3[3];

  state_t          state, state_nxt;
  logic [PH_W-1:0] timer, timer_nxt;
  logic [2:0]      phase_nxt;
  logic            running_nxt;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    phase_nxt   = 3'b000;
    running_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_start) state_nxt = phase_after(S_IDLE, course_sel);
      end
      S_WASH, S_RINSE, S_DRY: begin
        // Abort takes priority over the terminal count.
        if (press_start)          state_nxt = S_IDLE;
        else if (timer == PH_LAST) state_nxt = phase_after(state, course_sel);
        else                       timer_nxt = timer + PH_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_WASH:  begin phase_nxt = 3'b100; running_nxt = 1'b1; end
      S_RINSE: begin phase_nxt = 3'b010; running_nxt = 1'b1; end
      S_DRY:   begin phase_nxt = 3'b001; running_nxt = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      timer      <= '0;
      running    <= 1'b0;
      phase      <= 3'b000;
      done       <= 1'b0;
      course_sel <= 3'b111;
      water_lvl  <= 2'b10;
      temp_sel   <= 2'b01;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      running <= running_nxt;
      phase   <= phase_nxt;
      done    <= (state_nxt == S_DONE);
      // Setting presses outside IDLE, or alongside start, are dropped.
      if (state == S_IDLE && !press_start) begin
        if (press_course) course_sel <= next_course(course_sel);
        if (press_water)  water_lvl  <= next_level(water_lvl);
        if (press_temp)   temp_sel   <= next_level(temp_sel);
      end
    end
  end

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Directed bench for wm_panel_ctrl: table of setting presses plus
// hand-written run, abort and reset sequences.
module tb_wm_panel_ctrl;
  localparam int DB = 16;
  localparam int PC = 64;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_course, btn_water, btn_temp, btn_start;
  logic [2:0] course_sel;
  logic [1:0] water_lvl;
  logic [1:0] temp_sel;
  logic       running;
  logic [2:0] phase;
  logic       done;

  int checks = 0;
  int errors = 0;

  wm_panel_ctrl #(.DEBOUNCE_CYC(DB), .PHASE_CYC(PC)) dut (
    .clk(clk), .rstn(rstn),
    .btn_course(btn_course), .btn_water(btn_water),
    .btn_temp(btn_temp), .btn_start(btn_start),
    .course_sel(course_sel), .water_lvl(water_lvl), .temp_sel(temp_sel),
    .running(running), .phase(phase), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         btn;
    int         hold;
    logic [2:0] course;
    logic [1:0] water;
    logic [1:0] temp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_course = v;
      1: btn_water  = v;
      2: btn_temp   = v;
      default: btn_start = v;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    btn_course = 1'b0; btn_water = 1'b0; btn_temp = 1'b0; btn_start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic apply_press(input int b, input int hold);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (DB + 8) @(negedge clk);
  endtask

  // Raise start, confirm nothing moves through edge k+18, entry at edge k+19.
  task automatic start_run(input string tag, input logic [2:0] first_ph);
    @(negedge clk);
    btn_start = 1'b1;
    repeat (19) @(posedge clk);
    #1 check({tag, "_pre_running"}, running, 1'b0);
    @(posedge clk);
    #1 check({tag, "_entry_running"}, running, 1'b1);
    check({tag, "_entry_phase"}, phase, first_ph);
    btn_start = 1'b0;
  endtask

  // Called #1 after a phase entry edge; returns #1 after the edge that ends it.
  task automatic span_phase(input string tag, input logic [2:0] ph);
    repeat (PC - 1) @(posedge clk);
    #1 check({tag, "_last_cycle"}, phase, ph);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    btn_course = 1'b0; btn_water = 1'b0; btn_temp = 1'b0; btn_start = 1'b0;

    vecs[0]  = '{1, 5,  3'b111, 2'b10, 2'b01};
    vecs[1]  = '{1, 30, 3'b111, 2'b11, 2'b01};
    vecs[2]  = '{1, 30, 3'b111, 2'b01, 2'b01};
    vecs[3]  = '{1, 30, 3'b111, 2'b10, 2'b01};
    vecs[4]  = '{2, 30, 3'b111, 2'b10, 2'b10};
    vecs[5]  = '{2, 30, 3'b111, 2'b10, 2'b11};
    vecs[6]  = '{2, 30, 3'b111, 2'b10, 2'b01};
    vecs[7]  = '{0, 30, 3'b100, 2'b10, 2'b01};
    vecs[8]  = '{0, 30, 3'b010, 2'b10, 2'b01};
    vecs[9]  = '{0, 30, 3'b001, 2'b10, 2'b01};
    vecs[10] = '{0, 30, 3'b110, 2'b10, 2'b01};
    vecs[11] = '{0, 30, 3'b011, 2'b10, 2'b01};
    vecs[12] = '{0, 30, 3'b111, 2'b10, 2'b01};
    vecs[13] = '{0, 30, 3'b100, 2'b10, 2'b01};

    do_reset();
    #1;
    check("rst_course", course_sel, 3'b111);
    check("rst_water", water_lvl, 2'b10);
    check("rst_temp", temp_sel, 2'b01);
    check("rst_running", running, 1'b0);
    check("rst_phase", phase, 3'b000);
    check("rst_done", done, 1'b0);

    for (int i = 0; i < 14; i++) begin
      apply_press(vecs[i].btn, vecs[i].hold);
      check($sformatf("vec%0d_course", i), course_sel, vecs[i].course);
      check($sformatf("vec%0d_water", i), water_lvl, vecs[i].water);
      check($sformatf("vec%0d_temp", i), temp_sel, vecs[i].temp);
    end

    // Exact press latency: edge k+18 unchanged, edge k+19 updated.
    do_reset();
    @(negedge clk);
    btn_water = 1'b1;
    repeat (19) @(posedge clk);
    #1 check("lat_water_before", water_lvl, 2'b10);
    @(posedge clk);
    #1 check("lat_water_after", water_lvl, 2'b11);
    btn_water = 1'b0;
    repeat (DB + 8) @(negedge clk);

    // Full course: wash, rinse, dry, done pulse, idle.
    do_reset();
    start_run("full", 3'b100);
    span_phase("full_wash", 3'b100);
    check("full_rinse_phase", phase, 3'b010);
    span_phase("full_rinse", 3'b010);
    check("full_dry_phase", phase, 3'b001);
    span_phase("full_dry", 3'b001);
    check("full_done", done, 1'b1);
    check("full_done_phase", phase, 3'b000);
    check("full_done_running", running, 1'b0);
    @(posedge clk);
    #1 check("full_done_pulse_end", done, 1'b0);
    check("full_idle_running", running, 1'b0);
    check("full_course_kept", course_sel, 3'b111);

    // Rinse-only course.
    do_reset();
    apply_press(0, 30);
    apply_press(0, 30);
    check("rinse_only_course", course_sel, 3'b010);
    start_run("rinse_only", 3'b010);
    span_phase("rinse_only_rinse", 3'b010);
    check("rinse_only_done", done, 1'b1);
    check("rinse_only_phase_off", phase, 3'b000);
    @(posedge clk);
    #1 check("rinse_only_done_end", done, 1'b0);

    // Abort during rinse.
    do_reset();
    start_run("abort", 3'b100);
    span_phase("abort_wash", 3'b100);
    check("abort_rinse_phase", phase, 3'b010);
    @(negedge clk);
    btn_start = 1'b1;
    repeat (19) @(posedge clk);
    #1 check("abort_pre_phase", phase, 3'b010);
    @(posedge clk);
    #1 check("abort_phase", phase, 3'b000);
    check("abort_running", running, 1'b0);
    check("abort_done", done, 1'b0);
    btn_start = 1'b0;
    @(posedge clk);
    #1 check("abort_no_done_later", done, 1'b0);
    repeat (DB + 8) @(negedge clk);

    // Water press during wash ignored, then reset mid-dry.
    do_reset();
    apply_press(1, 30);
    check("mid_water_idle", water_lvl, 2'b11);
    start_run("mid", 3'b100);
    @(negedge clk);
    btn_water = 1'b1;
    repeat (25) @(negedge clk);
    btn_water = 1'b0;
    repeat (38) @(posedge clk);
    #1 check("mid_wash_last", phase, 3'b100);
    check("mid_water_held", water_lvl, 2'b11);
    @(posedge clk);
    #1 check("mid_rinse", phase, 3'b010);
    span_phase("mid_rinse", 3'b010);
    check("mid_dry", phase, 3'b001);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1 check("mid_rst_course", course_sel, 3'b111);
    check("mid_rst_water", water_lvl, 2'b10);
    check("mid_rst_temp", temp_sel, 2'b01);
    check("mid_rst_running", running, 1'b0);
    check("mid_rst_phase", phase, 3'b000);
    check("mid_rst_done", done, 1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1 check("mid_rst_no_done", done, 1'b0);

    // Start and course press together: start wins, old course used.
    do_reset();
    @(negedge clk);
    btn_start = 1'b1;
    btn_course = 1'b1;
    repeat (19) @(posedge clk);
    #1 check("both_pre_running", running, 1'b0);
    @(posedge clk);
    #1 check("both_phase", phase, 3'b100);
    check("both_course", course_sel, 3'b111);
    btn_start = 1'b0;
    btn_course = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check("both_course_later", course_sel, 3'b111);
    btn_start = 1'b1;
    repeat (19) @(posedge clk);
    #1 check("both_abort_pre", running, 1'b1);
    @(posedge clk);
    #1 check("both_abort_running", running, 1'b0);
    check("both_abort_done", done, 1'b0);
    btn_start = 1'b0;
    repeat (DB + 8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
